beta_mem_seq: RTL and testbench

//  Multi-cycle memory sequencer for the beta core with one shared memory port.

---
 rtl/beta_pkg.sv | 18 +
 rtl/mem_wait_timer.sv | 31 +++
 rtl/beta_mem_seq.sv | 122 ++++++++++++
 tb/tb_beta_mem_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// Shared types and default widths for the beta memory sequencer.
// State encoding is shared by the sequencer top and its users.
package beta_pkg;

    localparam int unsigned AW_DEF      = 32;
    localparam int unsigned DW_DEF      = 32;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        DATA,
        COMMIT,
        ERR
    } seq_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Per-access wait counter with bus-error compare.
// A TIMEOUT of zero never expires.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] r_cnt;

    // Saturate at LIMIT so a disabled timer never wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (tick && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/beta_mem_seq.sv
// Multi-cycle sequencer sharing one memory port between fetch and data.
// Stall is released for a single COMMIT cycle per instruction.
module beta_mem_seq
    import beta_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ia,
    output logic [DW-1:0] id,
    input  logic          data_rd,
    input  logic          data_wr,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          stall,
    output logic          bus_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    seq_state_t    r_state;
    seq_state_t    w_next;
    logic [DW-1:0] r_id;
    logic [DW-1:0] r_rdata;
    logic          r_is_wr;
    logic          r_bus_err;
    logic          w_in_acc;
    logic          w_clear;
    logic          w_tick;
    logic          w_expired;

    assign w_in_acc = (r_state == FETCH) || (r_state == DATA);
    assign w_clear  = !w_in_acc;
    assign w_tick   = w_in_acc && !mem_ack;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .tick   (w_tick),
        .expired(w_expired)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: w_next = FETCH;
            FETCH: begin
                if (mem_ack) begin
                    w_next = DECODE;
                end else if (w_expired) begin
                    w_next = ERR;
                end
            end
            DECODE: begin
                if (data_wr || data_rd) begin
                    w_next = DATA;
                end else begin
                    w_next = COMMIT;
                end
            end
            DATA: begin
                if (mem_ack) begin
                    w_next = COMMIT;
                end else if (w_expired) begin
                    w_next = ERR;
                end
            end
            COMMIT: w_next = FETCH;
            ERR: w_next = ERR;
            default: w_next = IDLE;
        endcase
    end

    // Write wins over read when both are requested in DECODE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_rdata   <= '0;
            r_is_wr   <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == FETCH) && mem_ack) begin
                r_id <= mem_rdata;
            end
            if (r_state == DECODE) begin
                r_is_wr <= data_wr;
            end
            if ((r_state == DATA) && mem_ack && !r_is_wr) begin
                r_rdata <= mem_rdata;
            end
            if (w_next == ERR) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        stall     = (r_state != COMMIT);
        mem_re    = (r_state == FETCH) || ((r_state == DATA) && !r_is_wr);
        mem_we    = (r_state == DATA) && r_is_wr;
        mem_addr  = (r_state == DATA) ? data_addr : ia;
        mem_wdata = data_wdata;
    end

    assign id         = r_id;
    assign data_rdata = r_rdata;
    assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_beta_mem_seq.sv
// Bench for beta_mem_seq: instruction table, random instructions and
// hand-written reset/timeout sequences against a phase-level model.
module tb_beta_mem_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ia;
    logic [31:0] id;
    logic        data_rd;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        stall;
    logic        bus_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    beta_mem_seq #(
        .AW(32),
        .DW(32),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ia        (ia),
        .id        (id),
        .data_rd   (data_rd),
        .data_wr   (data_wr),
        .data_addr (data_addr),
        .data_wdata(data_wdata),
        .data_rdata(data_rdata),
        .stall     (stall),
        .bus_err   (bus_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // op: 0 none, 1 read, 2 write, 3 read+write (write wins)
    typedef struct {
        logic [1:0]  op;
        int          wf;
        int          wd;
        logic [31:0] ia;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] fword;
        logic [31:0] lword;
        int          cpi;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_drd;
    vec_t        tbl[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input int wf,
                                input int wd, input logic [31:0] a,
                                input logic [31:0] da, input logic [31:0] wv,
                                input logic [31:0] fw, input logic [31:0] lw,
                                input int cpi);
        vec_t v;
        v.op = op; v.wf = wf; v.wd = wd; v.ia = a; v.daddr = da;
        v.wdata = wv; v.fword = fw; v.lword = lw; v.cpi = cpi;
        return v;
    endfunction

    task automatic drive_idle();
        ia = '0; data_rd = 0; data_wr = 0; data_addr = '0;
        data_wdata = '0; mem_rdata = '0; mem_ack = 0;
    endtask

    // Entered one step after the edge that lands the DUT in FETCH.
    task automatic run_instr(input vec_t v);
        int nd;
        int total;
        int first_low;
        nd = (v.op != 2'b00) ? v.wd + 1 : 0;
        total = v.wf + 1 + 1 + nd + 1;
        first_low = -1;
        for (int k = 0; k < total; k++) begin
            int ph;
            int j;
            j = 0;
            if (k <= v.wf) begin
                ph = 0; j = k;
            end else if (k == v.wf + 1) begin
                ph = 1;
            end else if (k < v.wf + 2 + nd) begin
                ph = 2; j = k - (v.wf + 2);
            end else begin
                ph = 3;
            end
            ia = v.ia; data_rd = v.op[0]; data_wr = v.op[1];
            data_addr = v.daddr; data_wdata = v.wdata;
            if (ph == 0) begin
                mem_ack = (j == v.wf); mem_rdata = v.fword;
            end else if (ph == 2) begin
                mem_ack = (j == v.wd); mem_rdata = v.lword;
            end else begin
                mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            end
            if (ph == 3 && v.op == 2'b01) m_drd = v.lword;
            #1;
            if (!stall && first_low < 0) first_low = k;
            check("stall", stall, ph != 3);
            check("mem_re", mem_re, (ph == 0) || (ph == 2 && v.op == 2'b01));
            check("mem_we", mem_we, (ph == 2) && v.op[1]);
            check("mem_addr", mem_addr, (ph == 2) ? v.daddr : v.ia);
            check("mem_wdata", mem_wdata, v.wdata);
            check("bus_err", bus_err, 0);
            if (ph != 0) check("id", id, v.fword);
            if (ph == 3) check("data_rdata", data_rdata, m_drd);
            @(posedge clk); #1;
        end
        check("cpi", first_low + 1, v.cpi);
    endtask

    // Returns one step into the IDLE cycle's successor (FETCH).
    task automatic do_reset();
        drive_idle();
        reset = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1;
        m_drd = '0;
        #1;
        check("rst_stall", stall, 1);
        check("rst_re", mem_re, 0);
        check("rst_we", mem_we, 0);
        check("rst_id", id, 0);
        check("rst_drd", data_rdata, 0);
        check("rst_buserr", bus_err, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0] = mk(2'd0, 0, 0, 32'h0000_0000, 32'h0, 32'h0, 32'h8000_1000, 32'h0, 3);
        tbl[1] = mk(2'd0, 0, 0, 32'h0000_0004, 32'h0, 32'h0, 32'h8000_2000, 32'h0, 3);
        tbl[2] = mk(2'd0, 0, 0, 32'h0000_0008, 32'h0, 32'h0, 32'h8000_3000, 32'h0, 3);
        tbl[3] = mk(2'd1, 2, 2, 32'h0000_000C, 32'h200, 32'h0, 32'h6000_0000, 32'hDEADBEEF, 8);
        tbl[4] = mk(2'd1, 2, 2, 32'h0000_0010, 32'h204, 32'h0, 32'h6000_0004, 32'hDEADBEEF, 8);
        tbl[5] = mk(2'd2, 0, 0, 32'h0000_0014, 32'h100, 32'h12345678, 32'h6400_0000, 32'h0, 4);
        tbl[6] = mk(2'd3, 0, 0, 32'h0000_0018, 32'h104, 32'hCAFEF00D, 32'h6400_0004, 32'h5555_AAAA, 4);
        tbl[7] = mk(2'd1, 1, 0, 32'h0000_001C, 32'h208, 32'h0, 32'h6000_0008, 32'h0BAD_F00D, 5);
        tbl[8] = mk(2'd0, 3, 0, 32'h0000_0020, 32'h0, 32'h0, 32'h8000_4000, 32'h0, 6);

        do_reset();
        for (int i = 0; i < 9; i++) run_instr(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.op = 2'($urandom_range(0, 3));
            v.wf = $urandom_range(0, 3);
            v.wd = $urandom_range(0, 3);
            v.ia = $urandom; v.daddr = $urandom; v.wdata = $urandom;
            v.fword = $urandom; v.lword = $urandom;
            v.cpi = v.wf + 3 + ((v.op != 2'b00) ? v.wd + 1 : 0);
            run_instr(v);
        end

        // Reset asserted for one cycle while a store is in DATA.
        ia = 32'h40; data_wr = 1; data_rd = 0; data_addr = 32'h100;
        data_wdata = 32'h1111_2222; mem_rdata = 32'h7000_0000; mem_ack = 1;
        @(posedge clk); #1;
        mem_ack = 0;
        @(posedge clk); #1;
        reset = 0;
        #1;
        check("mid_we_before", mem_we, 1);
        @(posedge clk); #1;
        reset = 1; mem_ack = 0;
        m_drd = '0;
        #1;
        check("mid_we", mem_we, 0);
        check("mid_re", mem_re, 0);
        check("mid_stall", stall, 1);
        check("mid_buserr", bus_err, 0);
        check("mid_id", id, 0);
        @(posedge clk); #1;
        run_instr(mk(2'd0, 0, 0, 32'h44, 32'h0, 32'h0, 32'h8000_5000, 32'h0, 3));

        // Fetch never acknowledged: five FETCH cycles, then ERR.
        ia = 32'h48; data_rd = 0; data_wr = 0; mem_ack = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("to_fetch_re", mem_re, 1);
            check("to_fetch_err", bus_err, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 22; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            #1;
            check("err_buserr", bus_err, 1);
            check("err_re", mem_re, 0);
            check("err_we", mem_we, 0);
            check("err_stall", stall, 1);
            @(posedge clk); #1;
        end

        do_reset();
        run_instr(tbl[5]);
        run_instr(tbl[3]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
